// File: rtl/pwm_capture_if.sv
// Signal bundle for the PWM capture block: capture controls in, measurement results and stuck flags out.
interface pwm_capture_if #(parameter int WIDTH = 16);
    logic             enable;
    logic             pwm_in;
    logic [WIDTH-1:0] period_meas;
    logic [WIDTH-1:0] duty_meas;
    logic             valid;
    logic             stuck_low;
    logic             stuck_high;

    modport master (
        output enable, pwm_in,
        input  period_meas, duty_meas, valid, stuck_low, stuck_high
    );

    modport slave (
        input  enable, pwm_in,
        output period_meas, duty_meas, valid, stuck_low, stuck_high
    );
endinterface

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in clk cycles and flags an input that
// stops toggling. The first partial period after reset, disable or a stuck condition is discarded.
module pwm_capture #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          reset_n,
    pwm_capture_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);

    state_t           state_r, state_s;
    logic             sync1_r, sync2_r, sync3_r;
    logic             rise_r, fall_r;
    logic [WIDTH-1:0] per_cnt_r, per_cnt_s;
    logic [WIDTH-1:0] high_cnt_r, high_cnt_s;
    logic [WIDTH-1:0] period_r, period_s;
    logic [WIDTH-1:0] duty_r, duty_s;
    logic             valid_r, valid_s;
    logic             stuck_low_r, stuck_low_s;
    logic             stuck_high_r, stuck_high_s;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] value);
        return (value == CNT_MAX) ? value : value + CNT_ONE;
    endfunction

    // Synchronizer and registered edge flags; sync3_r is the level aligned with rise_r/fall_r
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            {sync1_r, sync2_r, sync3_r, rise_r, fall_r} <= 5'b0;
        end else begin
            sync1_r <= bus.pwm_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            rise_r  <= sync2_r & ~sync3_r;
            fall_r  <= ~sync2_r & sync3_r;
        end
    end

    // Next-state, counter and result logic
    always_comb begin
        state_s      = state_r;
        per_cnt_s    = per_cnt_r;
        high_cnt_s   = high_cnt_r;
        period_s     = period_r;
        duty_s       = duty_r;
        valid_s      = 1'b0;
        stuck_low_s  = stuck_low_r;
        stuck_high_s = stuck_high_r;
        if (!bus.enable) begin
            state_s      = IDLE;
            per_cnt_s    = '0;
            high_cnt_s   = '0;
            stuck_low_s  = 1'b0;
            stuck_high_s = 1'b0;
        end else if (rise_r) begin
            if (state_r == MEASURE) begin
                period_s = per_cnt_r;
                duty_s   = high_cnt_r;
                valid_s  = 1'b1;
            end else begin
                valid_s  = 1'b0;
            end
            state_s      = MEASURE;
            per_cnt_s    = CNT_ONE;
            high_cnt_s   = CNT_ONE;
            stuck_low_s  = 1'b0;
            stuck_high_s = 1'b0;
        end else begin
            case (state_r)
                IDLE, MEASURE: begin
                    if (per_cnt_r >= TIMEOUT_C) begin
                        state_s      = STUCK;
                        stuck_high_s = sync3_r;
                        stuck_low_s  = ~sync3_r;
                    end else begin
                        per_cnt_s = sat_inc(per_cnt_r);
                        if ((state_r == MEASURE) && sync3_r) begin
                            high_cnt_s = sat_inc(high_cnt_r);
                        end else begin
                            high_cnt_s = high_cnt_r;
                        end
                    end
                end
                STUCK: begin
                    if (fall_r) begin
                        state_s      = IDLE;
                        per_cnt_s    = CNT_ONE;
                        high_cnt_s   = '0;
                        stuck_low_s  = 1'b0;
                        stuck_high_s = 1'b0;
                    end else begin
                        state_s = STUCK;
                    end
                end
                default: begin
                    state_s      = IDLE;
                    per_cnt_s    = '0;
                    high_cnt_s   = '0;
                    stuck_low_s  = 1'b0;
                    stuck_high_s = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            per_cnt_r    <= '0;
            high_cnt_r   <= '0;
            period_r     <= '0;
            duty_r       <= '0;
            valid_r      <= 1'b0;
            stuck_low_r  <= 1'b0;
            stuck_high_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            per_cnt_r    <= per_cnt_s;
            high_cnt_r   <= high_cnt_s;
            period_r     <= period_s;
            duty_r       <= duty_s;
            valid_r      <= valid_s;
            stuck_low_r  <= stuck_low_s;
            stuck_high_r <= stuck_high_s;
        end
    end

    assign bus.period_meas = period_r;
    assign bus.duty_meas   = duty_r;
    assign bus.valid       = valid_r;
    assign bus.stuck_low   = stuck_low_r;
    assign bus.stuck_high  = stuck_high_r;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: PWM streams with hand-computed period/duty, valid timing and stuck detection.
module tb_pwm_capture;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset_n;

    pwm_capture_if #(.WIDTH(WIDTH)) bus ();

    pwm_capture #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int per;
        int duty;
    } meas_t;

    meas_t vq[$];
    int    rq[$];
    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;
    logic  flags_seen = 1'b0;
    logic  both_seen  = 1'b0;

    // One clock: drive pwm_in, sample outputs 1 time unit after the edge and log valid pulses.
    task automatic step(input logic level);
        meas_t m;
        bus.pwm_in = level;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.valid === 1'b1) begin
            m.cyc  = cyc;
            m.per  = int'(bus.period_meas);
            m.duty = int'(bus.duty_meas);
            vq.push_back(m);
        end
        if (bus.stuck_low === 1'b1 || bus.stuck_high === 1'b1) flags_seen = 1'b1;
        if (bus.stuck_low === 1'b1 && bus.stuck_high === 1'b1) both_seen = 1'b1;
    endtask

    // n periods of 'per' cycles, first 'hi' high; rq gets the step index of each first-high sample.
    task automatic pwm_periods(input int per, input int hi, input int n);
        for (int p = 0; p < n; p++) begin
            rq.push_back(cyc + 1);
            for (int i = 0; i < per; i++) step((i < hi) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        bus.enable = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1);
        checks++;
        if (bus.period_meas !== 16'd0) begin errors++; $display("FAIL reset_period: got %0d, expected 0", bus.period_meas); end
        checks++;
        if (bus.duty_meas !== 16'd0) begin errors++; $display("FAIL reset_duty: got %0d, expected 0", bus.duty_meas); end
        checks++;
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", bus.valid); end
        checks++;
        if (bus.stuck_low !== 1'b0) begin errors++; $display("FAIL reset_stuck_low: got %b, expected 0", bus.stuck_low); end
        checks++;
        if (bus.stuck_high !== 1'b0) begin errors++; $display("FAIL reset_stuck_high: got %b, expected 0", bus.stuck_high); end
        // pwm_in already high at release counts as a discarded first edge
        reset_n = 1'b1;
        vq.delete();
        for (int i = 0; i < 10; i++) step((i < 4) ? 1'b1 : 1'b0);
        checks++;
        if (vq.size() !== 0) begin errors++; $display("FAIL reset_release_high: got %0d valid pulses, expected 0", vq.size()); end
    endtask

    task automatic test_basic();
        vq.delete();
        rq.delete();
        pwm_periods(10, 4, 5);
        checks++;
        if (vq.size() !== 5) begin errors++; $display("FAIL basic_count: got %0d valid pulses, expected 5", vq.size()); end
        for (int i = 0; i < 5 && i < vq.size(); i++) begin
            checks++;
            if (vq[i].cyc !== rq[i] + 3 || vq[i].per !== 10 || vq[i].duty !== 4) begin
                errors++;
                $display("FAIL basic_meas[%0d]: got cycle %0d %0d/%0d, expected cycle %0d 10/4",
                         i, vq[i].cyc, vq[i].per, vq[i].duty, rq[i] + 3);
            end
        end
    endtask

    task automatic test_duty_change();
        int exp_per[6]  = '{10, 10, 10, 10, 16, 16};
        int exp_duty[6] = '{4, 7, 7, 7, 8, 8};
        vq.delete();
        rq.delete();
        pwm_periods(10, 7, 3);
        pwm_periods(16, 8, 3);
        checks++;
        if (vq.size() !== 6) begin errors++; $display("FAIL duty_count: got %0d valid pulses, expected 6", vq.size()); end
        for (int i = 0; i < 6 && i < vq.size(); i++) begin
            checks++;
            if (vq[i].cyc !== rq[i] + 3 || vq[i].per !== exp_per[i] || vq[i].duty !== exp_duty[i]) begin
                errors++;
                $display("FAIL duty_meas[%0d]: got cycle %0d %0d/%0d, expected cycle %0d %0d/%0d",
                         i, vq[i].cyc, vq[i].per, vq[i].duty, rq[i] + 3, exp_per[i], exp_duty[i]);
            end
        end
    endtask

    task automatic test_stuck_low();
        int rl, n0, k;
        pwm_periods(10, 4, 1);
        rl = cyc + 1;
        pwm_periods(10, 4, 1);
        n0 = vq.size();
        while (bus.stuck_low !== 1'b1 && cyc < rl + 200) step(1'b0);
        checks++;
        if (cyc !== rl + 67) begin errors++; $display("FAIL stuck_low_time: got cycle %0d, expected %0d", cyc, rl + 67); end
        checks++;
        if (bus.stuck_high !== 1'b0) begin errors++; $display("FAIL stuck_low_other: stuck_high %b, expected 0", bus.stuck_high); end
        checks++;
        if (bus.period_meas !== 16'd10 || bus.duty_meas !== 16'd4) begin
            errors++; $display("FAIL stuck_low_hold: got %0d/%0d, expected 10/4", bus.period_meas, bus.duty_meas);
        end
        for (int i = 0; i < 5; i++) step(1'b0);
        checks++;
        if (bus.stuck_low !== 1'b1) begin errors++; $display("FAIL stuck_low_level: got %b, expected 1", bus.stuck_low); end
        k = cyc + 1;
        for (int i = 0; i < 3; i++) step(1'b1);
        checks++;
        if (bus.stuck_low !== 1'b1) begin errors++; $display("FAIL stuck_low_before_clear: got %b at cycle %0d, expected 1", bus.stuck_low, cyc); end
        step(1'b1);
        checks++;
        if (bus.stuck_low !== 1'b0 || cyc !== k + 3) begin
            errors++; $display("FAIL stuck_low_clear: got %b at cycle %0d, expected 0 at %0d", bus.stuck_low, cyc, k + 3);
        end
        for (int i = 0; i < 6; i++) step(1'b0);
        checks++;
        if (vq.size() !== n0) begin errors++; $display("FAIL stuck_low_no_valid: got %0d pulses, expected %0d", vq.size(), n0); end
        rq.delete();
        pwm_periods(10, 4, 1);
        checks++;
        if (vq.size() !== n0 + 1 || vq[vq.size()-1].per !== 10 || vq[vq.size()-1].duty !== 4 ||
            vq[vq.size()-1].cyc !== rq[0] + 3) begin
            errors++; $display("FAIL stuck_low_resume: got %0d pulses, expected %0d with 10/4 at cycle %0d", vq.size(), n0 + 1, rq[0] + 3);
        end
    endtask

    task automatic test_stuck_high();
        int rh, n0, f;
        n0 = vq.size();
        rh = cyc + 1;
        while (bus.stuck_high !== 1'b1 && cyc < rh + 200) step(1'b1);
        checks++;
        if (cyc !== rh + 67) begin errors++; $display("FAIL stuck_high_time: got cycle %0d, expected %0d", cyc, rh + 67); end
        checks++;
        if (bus.stuck_low !== 1'b0) begin errors++; $display("FAIL stuck_high_other: stuck_low %b, expected 0", bus.stuck_low); end
        checks++;
        if (vq.size() !== n0 + 1) begin errors++; $display("FAIL stuck_high_valids: got %0d pulses, expected %0d", vq.size(), n0 + 1); end
        f = cyc + 1;
        for (int i = 0; i < 3; i++) step(1'b0);
        checks++;
        if (bus.stuck_high !== 1'b1) begin errors++; $display("FAIL stuck_high_before_fall: got %b, expected 1", bus.stuck_high); end
        step(1'b0);
        checks++;
        if (bus.stuck_high !== 1'b0 || cyc !== f + 3) begin
            errors++; $display("FAIL stuck_high_clear: got %b at cycle %0d, expected 0 at %0d", bus.stuck_high, cyc, f + 3);
        end
        vq.delete();
        rq.delete();
        for (int i = 0; i < 4; i++) step(1'b0);
        pwm_periods(10, 4, 2);
        checks++;
        if (vq.size() !== 1) begin
            errors++; $display("FAIL idle_discard: got %0d pulses, expected 1", vq.size());
        end else if (vq[0].cyc !== rq[1] + 3 || vq[0].per !== 10 || vq[0].duty !== 4) begin
            errors++; $display("FAIL idle_discard: got cycle %0d %0d/%0d, expected cycle %0d 10/4", vq[0].cyc, vq[0].per, vq[0].duty, rq[1] + 3);
        end
    endtask

    task automatic test_reset_mid();
        pwm_periods(10, 4, 1);
        for (int i = 0; i < 3; i++) step(1'b0);
        reset_n = 1'b0;
        step(1'b0);
        reset_n = 1'b1;
        checks++;
        if (bus.period_meas !== 16'd0 || bus.duty_meas !== 16'd0 || bus.valid !== 1'b0 ||
            bus.stuck_low !== 1'b0 || bus.stuck_high !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs: got %0d/%0d valid %b flags %b%b, expected all 0",
                               bus.period_meas, bus.duty_meas, bus.valid, bus.stuck_low, bus.stuck_high);
        end
        vq.delete();
        rq.delete();
        pwm_periods(10, 4, 3);
        checks++;
        if (vq.size() !== 2) begin
            errors++; $display("FAIL mid_reset_restart: got %0d pulses, expected 2", vq.size());
        end else if (vq[0].cyc !== rq[1] + 3 || vq[0].per !== 10 || vq[0].duty !== 4) begin
            errors++; $display("FAIL mid_reset_restart: got cycle %0d %0d/%0d, expected cycle %0d 10/4", vq[0].cyc, vq[0].per, vq[0].duty, rq[1] + 3);
        end
    endtask

    task automatic test_enable();
        int n0;
        pwm_periods(10, 4, 2);
        n0 = vq.size();
        flags_seen = 1'b0;
        bus.enable = 1'b0;
        pwm_periods(10, 4, 2);
        checks++;
        if (vq.size() !== n0) begin errors++; $display("FAIL disabled_valid: got %0d pulses, expected %0d", vq.size(), n0); end
        checks++;
        if (flags_seen !== 1'b0) begin errors++; $display("FAIL disabled_flags: got %b, expected 0", flags_seen); end
        checks++;
        if (bus.period_meas !== 16'd10 || bus.duty_meas !== 16'd4) begin
            errors++; $display("FAIL disabled_hold: got %0d/%0d, expected 10/4", bus.period_meas, bus.duty_meas);
        end
        bus.enable = 1'b1;
        vq.delete();
        rq.delete();
        pwm_periods(10, 4, 3);
        checks++;
        if (vq.size() !== 2) begin
            errors++; $display("FAIL reenable: got %0d pulses, expected 2", vq.size());
        end else if (vq[0].cyc !== rq[1] + 3 || vq[1].cyc !== rq[2] + 3 || vq[1].per !== 10 || vq[1].duty !== 4) begin
            errors++; $display("FAIL reenable: got cycles %0d,%0d %0d/%0d, expected %0d,%0d 10/4",
                               vq[0].cyc, vq[1].cyc, vq[1].per, vq[1].duty, rq[1] + 3, rq[2] + 3);
        end
    endtask

    initial begin
        bus.pwm_in = 1'b0;
        bus.enable = 1'b1;
        reset_n    = 1'b0;
        test_reset();
        test_basic();
        test_duty_change();
        test_stuck_low();
        test_stuck_high();
        test_reset_mid();
        test_enable();
        checks++;
        if (both_seen !== 1'b0) begin errors++; $display("FAIL flags_exclusive: both flags seen %b, expected 0", both_seen); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the bit width of the measurement counters and outputs.
REQ-002 SHALL have parameter TIMEOUT, default 65535, the number of cycles without a rising edge that declares a stuck input; legal range 2 .. 2^WIDTH-1.
REQ-003 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  capture enable, level-sensitive.
REQ-006 SHALL have port pwm_in  input  1  asynchronous PWM signal under measurement.
REQ-007 SHALL have port period_meas  output  WIDTH  last measured period in clk cycles.
REQ-008 SHALL have port duty_meas  output  WIDTH  last measured high time in clk cycles.
REQ-009 SHALL have port valid  output  1  one-cycle pulse when period_meas and duty_meas update.
REQ-010 SHALL have port stuck_low  output  1  level; input constant low for at least TIMEOUT cycles.
REQ-011 SHALL have port stuck_high  output  1  level; input constant high for at least TIMEOUT cycles.

Function
REQ-012 SHALL pass pwm_in through a 2-flop synchronizer; edge detection SHALL compare the synchronized level to a third registered copy.
REQ-013 SHALL implement states IDLE, MEASURE and STUCK, with IDLE the reset state.
REQ-014 SHALL maintain per_cnt and high_cnt (WIDTH bits), both saturating at 2^WIDTH-1 and never wrapping.
REQ-015 On a synchronized rising edge in any enabled state, SHALL load per_cnt=1 and high_cnt=1 and enter MEASURE.
REQ-016 In MEASURE with no rising edge, per_cnt SHALL increment each cycle, and high_cnt SHALL increment only while the synchronized level is 1.
REQ-017 On a rising edge in MEASURE, SHALL register period_meas=per_cnt and duty_meas=high_cnt, using the pre-reload values, and pulse valid for exactly one cycle.
REQ-018 A rising edge in IDLE or STUCK SHALL start a measurement without asserting valid, so the first partial period is discarded.
REQ-019 The valid pulse SHALL appear 3 clk cycles after the clk edge that first samples pwm_in high.
REQ-020 duty_meas SHALL always be less than or equal to period_meas; period_meas SHALL be at least 2 for any reported measurement.
REQ-021 In IDLE or MEASURE, when per_cnt reaches TIMEOUT with no rising edge, SHALL enter STUCK.
REQ-022 On entering STUCK, SHALL assert stuck_high if the synchronized level is 1, or stuck_low if it is 0; period_meas and duty_meas SHALL hold and valid SHALL stay 0.
REQ-023 In STUCK, a falling edge SHALL return to IDLE with flags cleared and per_cnt restarted at 1; a rising edge SHALL follow REQ-015; stuck_low and stuck_high SHALL clear in either case.
REQ-024 In IDLE, per_cnt SHALL count from reset or entry so that a never-toggling input reaches STUCK after TIMEOUT cycles.
REQ-025 When enable=0, SHALL synchronously force IDLE, clear the counters, stuck flags and valid, hold period_meas and duty_meas, and keep the synchronizer running.
REQ-026 stuck_low and stuck_high SHALL never both be 1.

Reset
REQ-027 With reset_n=0 at a clk edge, SHALL set state=IDLE, all counters=0, all synchronizer flops=0, period_meas=0, duty_meas=0, valid=0, stuck_low=0 and stuck_high=0.
REQ-028 Reset SHALL take priority over enable and abort any measurement in progress, with no valid emitted.
REQ-029 A pwm_in already high at reset release SHALL be treated as a rising edge per REQ-018, with no valid.

Verification
REQ-030 Scenario: PWM period 10, high 4 cycles, repeated -> from the second rising edge onward, valid pulses every 10 cycles with period_meas=10 and duty_meas=4.
REQ-031 Scenario: switch to high 7 of 10, then 8 of 16 -> after one transitional measurement, reports 10/7 and then 16/8, with valid spacing equal to the period.
REQ-032 Scenario: TIMEOUT=64 and pwm_in held low after a 10/4 stream -> stuck_low=1 at 64 cycles past the last rising edge, period_meas/duty_meas hold 10/4, and the next rising edge clears stuck_low with no valid.
REQ-033 Scenario: TIMEOUT=64 and pwm_in held high (duty = period) -> stuck_high=1 and stuck_low=0; a later falling edge clears stuck_high and returns to IDLE.
REQ-034 Scenario: reset_n=0 for one cycle mid-period -> all outputs are 0 the next cycle, and the first valid comes only after two further rising edges.
REQ-035 Scenario: enable=0 for 20 cycles during a 10/4 stream -> no valid and flags 0 while low, outputs hold 10/4, and valid resumes at the second rising edge after re-enable.
